// File: rtl/fft_pkg.sv
// Shared FFT chain definitions: read FSM states, index bit reversal
// and complex sample pack/unpack helpers.
package fft_pkg;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_e;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx16_t;

  // Reverses the low w bits of x; bits above w come back as zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] x,
    input int          w
  );
    logic [31:0] r;
    r = {<<{x}};
    return r >> (32 - w);
  endfunction

  function automatic logic [31:0] cplx_pack(
    input logic [15:0] re,
    input logic [15:0] im
  );
    return {re, im};
  endfunction

  function automatic cplx16_t cplx_unpack(
    input logic [31:0] d
  );
    return cplx16_t'(d);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array is left untouched.
module sdp_ram #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 2048,
  parameter int DEPTH_LOG = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic                 re,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [DWIDTH-1:0]    rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bitrev_reorder.sv
// Rewrites bit-reversed FFT output frames into natural order
// through a two-bank ping-pong RAM.
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FFT_LEN     = 1024,
  parameter int FFT_LEN_LOG = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  output logic              o_first,
  output logic              o_last,
  output logic              o_overflow
);

  localparam logic [FFT_LEN_LOG-1:0] LAST =
    FFT_LEN_LOG'(FFT_LEN - 1);

  logic [FFT_LEN_LOG-1:0] wr_cnt_q, wr_cnt_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [FFT_LEN_LOG-1:0] wr_idx;
  logic                   frame_done;

  rd_state_e              state_q, state_d;
  logic [FFT_LEN_LOG-1:0] rd_cnt_q, rd_cnt_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   rd_en;
  logic                   vld_q, vld_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   ovf_q, ovf_d;

  assign wr_idx =
    FFT_LEN_LOG'(bitrev(32'(wr_cnt_q), FFT_LEN_LOG));

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    frame_done = 1'b0;
    if (i_valid) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == LAST) begin
        frame_done = 1'b1;
        wr_bank_d  = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    ovf_d     = ovf_q;
    rd_en     = 1'b0;
    vld_d     = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_done) begin
          state_d   = READ;
          rd_bank_d = wr_bank_q;
          rd_cnt_d  = '0;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        vld_d    = 1'b1;
        first_d  = (rd_cnt_q == '0);
        last_d   = (rd_cnt_q == LAST);
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST) begin
          state_d = IDLE;
        end
        // A newly filled bank always wins, even mid-frame.
        if (frame_done) begin
          state_d   = READ;
          rd_bank_d = wr_bank_q;
          rd_cnt_d  = '0;
          if (rd_cnt_q != LAST) begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

  sdp_ram #(
    .DWIDTH   (DWIDTH),
    .DEPTH    (2 * FFT_LEN),
    .DEPTH_LOG(FFT_LEN_LOG + 1)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (i_valid),
    .waddr({wr_bank_q, wr_idx}),
    .wdata(i_data),
    .re   (rd_en),
    .raddr({rd_bank_q, rd_cnt_q}),
    .rdata(o_data)
  );

  assign o_valid    = vld_q;
  assign o_first    = first_q;
  assign o_last     = last_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bitrev_reorder.sv
// Directed + randomized bench for bitrev_reorder (N=16) against a
// frame-level model: each completed frame schedules N natural-order outputs.
module tb_bitrev_reorder;

  localparam int N  = 16;
  localparam int LG = 4;

  logic        clk;
  logic        reset;
  logic [31:0] i_data;
  logic        i_valid;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_first;
  logic        o_last;
  logic        o_overflow;

  bitrev_reorder #(
    .DWIDTH     (32),
    .FFT_LEN    (N),
    .FFT_LEN_LOG(LG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_first   (o_first),
    .o_last    (o_last),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t        sched[int];
  logic [31:0] mem[2][N];
  int          wcnt;
  int          wbank;
  logic        ovf;
  int          ecnt;
  int          checks;
  int          errors;

  function automatic int rev(input int x);
    int r;
    r = 0;
    for (int b = 0; b < LG; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, ecnt, got, exp);
    end
  endtask

  // Frame-level reference: a completed frame emits its natural-order
  // contents starting one edge later, preempting any pending frame.
  task automatic model_edge(input logic v, input logic [31:0] d,
                            input logic rst_n, input logic inject);
    int ks[$];
    if (!rst_n) begin
      wcnt  = 0;
      wbank = 0;
      ovf   = 1'b0;
      sched.delete();
      return;
    end
    if (!v) return;
    if (inject) wcnt = N - 1;
    mem[wbank][rev(wcnt)] = d;
    if (wcnt == N - 1) begin
      foreach (sched[k]) if (k > ecnt) ks.push_back(k);
      if (ks.size() > 0) ovf = 1'b1;
      foreach (ks[j]) sched.delete(ks[j]);
      for (int i = 0; i < N; i++)
        sched[ecnt + 1 + i] = '{mem[wbank][i], i == 0, i == N - 1};
      wbank = 1 - wbank;
      wcnt  = 0;
    end else begin
      wcnt++;
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] d,
                      input logic rst_n, input logic inject);
    logic ev;
    reset   = rst_n;
    i_valid = v;
    i_data  = d;
    if (inject) force dut.wr_cnt_q = 4'(N - 1);
    @(posedge clk);
    ecnt++;
    model_edge(v, d, rst_n, inject);
    #1;
    if (inject) release dut.wr_cnt_q;
    ev = sched.exists(ecnt);
    chk("o_valid", 32'(o_valid), 32'(ev));
    if (ev) begin
      chk("o_data", o_data, sched[ecnt].d);
      chk("o_first", 32'(o_first), 32'(sched[ecnt].f));
      chk("o_last", 32'(o_last), 32'(sched[ecnt].l));
      sched.delete(ecnt);
    end else begin
      chk("o_first_idle", 32'(o_first), 32'(0));
      chk("o_last_idle", 32'(o_last), 32'(0));
    end
    chk("o_overflow", 32'(o_overflow), 32'(ovf));
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic feed_frame(input logic pat, input logic [31:0] base,
                            input int gap_pct);
    int k;
    k = 0;
    while (k < N) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        tick(1'b0, '0, 1'b1, 1'b0);
      end else begin
        tick(1'b1, pat ? base + 32'(rev(k)) : $urandom, 1'b1, 1'b0);
        k++;
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    ecnt    = 0;
    wcnt    = 0;
    wbank   = 0;
    ovf     = 1'b0;
    reset   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;

    tick(1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("reset_o_data", o_data, 32'(0));
    idle(2);

    // single frame, natural-order ramp expected
    feed_frame(1'b1, 32'(0), 0);
    idle(20);

    // three back-to-back frames
    for (int f = 0; f < 3; f++) feed_frame(1'b1, 32'(f * N), 0);
    idle(20);

    // gapped input, same data as the first frame
    feed_frame(1'b1, 32'(0), 30);
    idle(20);

    // reset after a partial frame, then a fresh frame
    for (int i = 0; i < 7; i++) tick(1'b1, $urandom, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("partial_reset_o_data", o_data, 32'(0));
    idle(3);
    feed_frame(1'b0, '0, 0);
    idle(20);

    // reset while index 5 is on the output
    feed_frame(1'b0, '0, 0);
    idle(6);
    tick(1'b0, '0, 1'b0, 1'b0);
    chk("midread_reset_o_data", o_data, 32'(0));
    idle(3);
    feed_frame(1'b0, '0, 0);
    idle(20);

    // injected frame_done mid-read
    feed_frame(1'b0, '0, 0);
    idle(5);
    tick(1'b1, $urandom, 1'b1, 1'b1);
    idle(24);
    tick(1'b0, '0, 1'b0, 1'b0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", ecnt);
    $fatal(1, "timeout");
  end

endmodule
